readout_tx_meas_sequencer: RTL and testbench
============================================

# readout_tx_meas_sequencer

Transmit-side measurement sequencer for one readout channel. Accepts a measurement request, drives the readout tone envelope (valid/amplitude) toward the upconversion/DAC path, and frames the integration window for the receive-side state decision unit with `start_count`/`finish_count` pulses. After the window closes, it waits for the receive path's measurement result and returns it to the requester, forming the initiator end of the readout request/result protocol.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of envelope amplitude and of config write data
- `COUNT_WIDTH`, 16, width of ring-up and integration-length counters
- `CFG_ADDR_WIDTH`, 2, config register address width
- `TIMEOUT_CYCLES`, 1024, result wait limit; used only with `READOUT_TX_RESULT_TIMEOUT_EN`

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  reset; asynchronous, active-low
- `cfg_wr_en`  in  1  config write strobe
- `cfg_wr_addr`  in  CFG_ADDR_WIDTH  0=integration length, 1=ring-up delay, 2=amplitude, 3=reserved (write ignored)
- `cfg_wr_data`  in  DATA_WIDTH  write data; lengths use the low COUNT_WIDTH bits
- `meas_req`  in  1  measurement request
- `req_ready`  out  1  high in IDLE; request accepted when `meas_req && req_ready`
- `tx_valid_out`  out  1  tone on
- `tx_amp_out`  out  DATA_WIDTH  envelope amplitude; 0 whenever `tx_valid_out`=0
- `rx_valid_out`  out  1  integration window; feeds RX `valid_in`
- `start_count`  out  1  one-cycle pulse on the first integration cycle
- `finish_count`  out  1  one-cycle pulse after the last integration cycle
- `valid_meas_result_in`  in  1  result strobe from RX
- `meas_result_in`  in  1  result bit from RX
- `result_valid_out`  out  1  one-cycle result pulse to requester
- `result_out`  out  1  measured state
- `timeout_out`  out  1  qualifies `result_valid_out`; 1 means timed out

## Operation
- FSM states:
  - IDLE: `req_ready`=1. On accept, snapshot length L, delay D and amplitude A. Go to RINGUP if D>0, else INTEGRATE.
  - RINGUP: tone on for D cycles, then INTEGRATE.
  - INTEGRATE: tone on with `rx_valid_out`=1 for L cycles, then DONE.
  - DONE: one cycle, `finish_count`=1, tone off, then WAIT_RESULT.
  - WAIT_RESULT: on `valid_meas_result_in`, register `meas_result_in`, pulse `result_valid_out`, go to IDLE.
- L=0 is treated as L=1.
- Config writes are allowed at any time. They update the registers only; a measurement in flight keeps its snapshot.
- Config reset values: L=1, D=0, A=0.
- `meas_req` while busy is ignored. It is not queued.
- `valid_meas_result_in` outside WAIT_RESULT is ignored.
- `rst` low at any time returns to IDLE asynchronously. All outputs go to 0 except `req_ready`, which is 1 once in IDLE. Config registers return to their reset values.
- Counters are COUNT_WIDTH down-counters loaded from the snapshot. There is no wrap: each state exits when its counter reaches 1.

## Timing
- Request accepted at cycle T:
  - `tx_valid_out`=1 for cycles T+1 through T+D+L.
  - `rx_valid_out`=1 for cycles T+D+1 through T+D+L.
  - `start_count`=1 at T+D+1, coincident with the first `rx_valid_out`.
  - `finish_count`=1 at T+D+L+1.
  - WAIT_RESULT from T+D+L+2.
- When L=1, `start_count` and the single `rx_valid_out` cycle coincide.
- Result strobe at cycle R gives `result_valid_out`=1 at R+1 and `req_ready`=1 at R+1. A new request can be accepted at R+1.
- All outputs are registered. `req_ready` is decoded from the state register.
- Back-to-back measurement period: D+L+3 cycles plus the RX result latency.

## Configuration
- `READOUT_TX_RESULT_TIMEOUT_EN` defined:
  - WAIT_RESULT also counts cycles.
  - If `valid_meas_result_in` has not arrived after TIMEOUT_CYCLES cycles, emit `result_valid_out`=1, `result_out`=0, `timeout_out`=1, and go to IDLE.
  - A result strobe arriving on the same cycle as the timeout wins, with `timeout_out`=0.
- Not defined:
  - WAIT_RESULT waits indefinitely.
  - `timeout_out` is tied to 0 and no timeout counter is built.

## Test plan
- Reset, no stimulus: all outputs 0 except `req_ready`=1. Write L=4, D=2, A=0x1234, then request at T:
  - `tx_valid_out` high T+1 through T+6, with `tx_amp_out`=0x1234.
  - `rx_valid_out` high T+3 through T+6.
  - `start_count` at T+3, `finish_count` at T+7.
- D=0, L=0: `start_count` and `rx_valid_out` both high at T+1 only; `finish_count` at T+2.
- Result at T+7+5=T+12 with `meas_result_in`=1: `result_valid_out`=1, `result_out`=1 at T+13; `req_ready`=1 at T+13.
- Request held high during the measurement, plus a config write of A=0x0F00 at T+2: no second start, and the current pulse keeps A=0x1234. The next measurement uses 0x0F00.
- `rst` driven low during INTEGRATE: outputs clear immediately and no `finish_count` is emitted. After release, IDLE with L=1, D=0, A=0.
- With the macro and TIMEOUT_CYCLES=8, no result returned: `result_valid_out`=1 and `timeout_out`=1 eight cycles after WAIT_RESULT is entered. Without the macro, the FSM stays in WAIT_RESULT.

Source files
------------

// File: rtl/readout_tx_meas_sequencer.sv
// Readout TX measurement sequencer: ring-up, integration window framing, and result return.
// Optional result-wait timeout is enabled by defining READOUT_TX_RESULT_TIMEOUT_EN.
module readout_tx_meas_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int COUNT_WIDTH    = 16,
  parameter int CFG_ADDR_WIDTH = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_wr_en,
  input  logic [CFG_ADDR_WIDTH-1:0] cfg_wr_addr,
  input  logic [DATA_WIDTH-1:0]     cfg_wr_data,
  input  logic                      meas_req,
  output logic                      req_ready,
  output logic                      tx_valid_out,
  output logic [DATA_WIDTH-1:0]     tx_amp_out,
  output logic                      rx_valid_out,
  output logic                      start_count,
  output logic                      finish_count,
  input  logic                      valid_meas_result_in,
  input  logic                      meas_result_in,
  output logic                      result_valid_out,
  output logic                      result_out,
  output logic                      timeout_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RINGUP,
    S_INTEGRATE,
    S_DONE,
    S_WAIT
  } state_t;

  state_t                 state, state_nxt;
  logic [COUNT_WIDTH-1:0] cfg_len, cfg_delay, len_eff, len_snap;
  logic [COUNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]  cfg_amp, amp_snap, amp_nxt;
  logic                   accept, tone_nxt, res_take;
`ifdef READOUT_TX_RESULT_TIMEOUT_EN
  localparam logic [COUNT_WIDTH-1:0] TO_LOAD = COUNT_WIDTH'(TIMEOUT_CYCLES);
  logic                   timeout_hit;
`endif

  // A zero integration length still produces a one-cycle window.
  assign len_eff   = (cfg_len == '0) ? COUNT_WIDTH'(1) : cfg_len;
  assign accept    = (state == S_IDLE) && meas_req;
  assign req_ready = (state == S_IDLE);
  assign amp_nxt   = accept ? cfg_amp : amp_snap;
  assign tone_nxt  = (state_nxt == S_RINGUP) || (state_nxt == S_INTEGRATE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_len   <= COUNT_WIDTH'(1);
      cfg_delay <= '0;
      cfg_amp   <= '0;
    end else if (cfg_wr_en) begin
      case (cfg_wr_addr)
        CFG_ADDR_WIDTH'(0): cfg_len   <= cfg_wr_data[COUNT_WIDTH-1:0];
        CFG_ADDR_WIDTH'(1): cfg_delay <= cfg_wr_data[COUNT_WIDTH-1:0];
        CFG_ADDR_WIDTH'(2): cfg_amp   <= cfg_wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      len_snap <= len_eff;
      amp_snap <= cfg_amp;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    res_take  = 1'b0;
`ifdef READOUT_TX_RESULT_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (meas_req) begin
          if (cfg_delay != '0) begin
            state_nxt = S_RINGUP;
            cnt_nxt   = cfg_delay;
          end else begin
            state_nxt = S_INTEGRATE;
            cnt_nxt   = len_eff;
          end
        end
      end
      S_RINGUP: begin
        if (cnt <= COUNT_WIDTH'(1)) begin
          state_nxt = S_INTEGRATE;
          cnt_nxt   = len_snap;
        end else begin
          cnt_nxt = cnt - COUNT_WIDTH'(1);
        end
      end
      S_INTEGRATE: begin
        if (cnt <= COUNT_WIDTH'(1)) state_nxt = S_DONE;
        else                        cnt_nxt   = cnt - COUNT_WIDTH'(1);
      end
      S_DONE: begin
        state_nxt = S_WAIT;
`ifdef READOUT_TX_RESULT_TIMEOUT_EN
        cnt_nxt   = TO_LOAD;
`endif
      end
      S_WAIT: begin
        // A strobe on the final timeout cycle takes priority over the timeout.
        if (valid_meas_result_in) begin
          res_take  = 1'b1;
          state_nxt = S_IDLE;
        end
`ifdef READOUT_TX_RESULT_TIMEOUT_EN
        else if (cnt <= COUNT_WIDTH'(1)) begin
          timeout_hit = 1'b1;
          state_nxt   = S_IDLE;
        end else begin
          cnt_nxt = cnt - COUNT_WIDTH'(1);
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output registers are loaded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_valid_out     <= 1'b0;
      tx_amp_out       <= '0;
      rx_valid_out     <= 1'b0;
      start_count      <= 1'b0;
      finish_count     <= 1'b0;
      result_valid_out <= 1'b0;
      result_out       <= 1'b0;
    end else begin
      tx_valid_out <= tone_nxt;
      tx_amp_out   <= tone_nxt ? amp_nxt : '0;
      rx_valid_out <= (state_nxt == S_INTEGRATE);
      start_count  <= (state_nxt == S_INTEGRATE) && (state != S_INTEGRATE);
      finish_count <= (state_nxt == S_DONE);
      result_out   <= res_take & meas_result_in;
`ifdef READOUT_TX_RESULT_TIMEOUT_EN
      result_valid_out <= res_take | timeout_hit;
`else
      result_valid_out <= res_take;
`endif
    end
  end

`ifdef READOUT_TX_RESULT_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) timeout_out <= 1'b0;
    else      timeout_out <= timeout_hit;
  end
`else
  assign timeout_out = 1'b0;
`endif

endmodule

// File: tb/tb_readout_tx_meas_sequencer.sv
// Directed bench for readout_tx_meas_sequencer with a timeline-based reference model.
module tb_readout_tx_meas_sequencer;

  localparam int DW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_wr_en;
  logic [1:0]    cfg_wr_addr;
  logic [DW-1:0] cfg_wr_data;
  logic          meas_req;
  logic          req_ready;
  logic          tx_valid_out;
  logic [DW-1:0] tx_amp_out;
  logic          rx_valid_out;
  logic          start_count;
  logic          finish_count;
  logic          valid_meas_result_in;
  logic          meas_result_in;
  logic          result_valid_out;
  logic          result_out;
  logic          timeout_out;

  readout_tx_meas_sequencer #(
    .DATA_WIDTH(DW), .COUNT_WIDTH(16), .CFG_ADDR_WIDTH(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .meas_req(meas_req), .req_ready(req_ready),
    .tx_valid_out(tx_valid_out), .tx_amp_out(tx_amp_out), .rx_valid_out(rx_valid_out),
    .start_count(start_count), .finish_count(finish_count),
    .valid_meas_result_in(valid_meas_result_in), .meas_result_in(meas_result_in),
    .result_valid_out(result_valid_out), .result_out(result_out), .timeout_out(timeout_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: one measurement described by its accept cycle and snapshot.
  int   m_cfg_l, m_cfg_d, m_cfg_a;
  bit   m_act;
  int   m_t, m_d, m_l, m_a;
  int   m_res_cyc;
  bit   m_res_bit, m_res_to;

  initial begin
    m_cfg_l = 1; m_cfg_d = 0; m_cfg_a = 0; m_act = 0; m_res_cyc = -1;
    m_t = 0; m_d = 0; m_l = 1; m_a = 0; m_res_bit = 0; m_res_to = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_ready", req_ready, 1);
        chk("rst_tx", tx_valid_out, 0);
        chk("rst_amp", tx_amp_out, 0);
        chk("rst_rx", rx_valid_out, 0);
        chk("rst_start", start_count, 0);
        chk("rst_finish", finish_count, 0);
        chk("rst_resv", result_valid_out, 0);
        chk("rst_to", timeout_out, 0);
        m_act = 0; m_res_cyc = -1;
        m_cfg_l = 1; m_cfg_d = 0; m_cfg_a = 0;
      end else begin
        bit e_tx, e_rx, e_rv;
        e_tx = m_act && cyc >= m_t + 1 && cyc <= m_t + m_d + m_l;
        e_rx = m_act && cyc >= m_t + m_d + 1 && cyc <= m_t + m_d + m_l;
        e_rv = (cyc == m_res_cyc);
        chk("ready", req_ready, !m_act);
        chk("tx_valid", tx_valid_out, e_tx);
        chk("tx_amp", tx_amp_out, e_tx ? m_a : 0);
        chk("rx_valid", rx_valid_out, e_rx);
        chk("start", start_count, m_act && cyc == m_t + m_d + 1);
        chk("finish", finish_count, m_act && cyc == m_t + m_d + m_l + 1);
        chk("res_valid", result_valid_out, e_rv);
        chk("timeout", timeout_out, e_rv && m_res_to);
        if (e_rv) chk("res_bit", result_out, m_res_bit);
        if (!m_act && meas_req) begin
          m_act = 1; m_t = cyc; m_d = m_cfg_d;
          m_l = (m_cfg_l == 0) ? 1 : m_cfg_l; m_a = m_cfg_a;
        end else if (m_act && cyc >= m_t + m_d + m_l + 2) begin
          if (valid_meas_result_in) begin
            m_act = 0; m_res_cyc = cyc + 1; m_res_bit = meas_result_in; m_res_to = 0;
          end
`ifdef READOUT_TX_RESULT_TIMEOUT_EN
          else if (cyc == m_t + m_d + m_l + 2 + TO - 1) begin
            m_act = 0; m_res_cyc = cyc + 1; m_res_bit = 0; m_res_to = 1;
          end
`endif
        end
        if (cfg_wr_en) begin
          case (cfg_wr_addr)
            2'd0: m_cfg_l = int'(cfg_wr_data);
            2'd1: m_cfg_d = int'(cfg_wr_data);
            2'd2: m_cfg_a = int'(cfg_wr_data);
            default: ;
          endcase
        end
      end
    end
  end

  initial begin
    repeat (3000) @(posedge clk);
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [DW-1:0] d);
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
  endtask

  int t, t2, t3, w, t4, t5, t6;

  initial begin
    rst = 1'b0; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    meas_req = 1'b0; valid_meas_result_in = 1'b0; meas_result_in = 1'b0;
    goto(3); rst = 1'b1;
    goto(4); wr(2'd0, 16'd4);
    goto(5); wr(2'd1, 16'd2);
    goto(6); wr(2'd2, 16'h1234);
    goto(7); cfg_wr_en = 1'b0; meas_req = 1'b1; t = cyc;
    @(negedge clk); chk("lit_idle_ready", req_ready, 1);
    goto(t + 1); @(negedge clk);
    chk("lit_tx_t1", tx_valid_out, 1); chk("lit_amp_t1", tx_amp_out, 16'h1234);
    goto(t + 2); wr(2'd2, 16'h0F00);
    @(negedge clk); chk("lit_rx_t2", rx_valid_out, 0);
    goto(t + 3); cfg_wr_en = 1'b0;
    @(negedge clk); chk("lit_start_t3", start_count, 1); chk("lit_rx_t3", rx_valid_out, 1);
    goto(t + 4); valid_meas_result_in = 1'b1; meas_result_in = 1'b1;
    goto(t + 5); valid_meas_result_in = 1'b0;
    @(negedge clk); chk("lit_early_res", result_valid_out, 0);
    goto(t + 6); @(negedge clk); chk("lit_amp_t6", tx_amp_out, 16'h1234);
    goto(t + 7); @(negedge clk);
    chk("lit_finish_t7", finish_count, 1); chk("lit_tx_t7", tx_valid_out, 0);
    goto(t + 12); valid_meas_result_in = 1'b1; meas_result_in = 1'b1;
    goto(t + 13); valid_meas_result_in = 1'b0;
    @(negedge clk);
    chk("lit_resv_t13", result_valid_out, 1); chk("lit_res_t13", result_out, 1);
    chk("lit_ready_t13", req_ready, 1);
    t2 = t + 13;
    goto(t2 + 1); meas_req = 1'b0;
    @(negedge clk); chk("lit_amp_new", tx_amp_out, 16'h0F00);
    goto(t2 + 9); valid_meas_result_in = 1'b1; meas_result_in = 1'b0;
    goto(t2 + 10); valid_meas_result_in = 1'b0;
    @(negedge clk); chk("lit_resv2", result_valid_out, 1); chk("lit_res2", result_out, 0);

    goto(t2 + 11); wr(2'd0, 16'd0);
    goto(t2 + 12); wr(2'd1, 16'd0);
    goto(t2 + 13); wr(2'd3, 16'hFFFF);
    goto(t2 + 14); cfg_wr_en = 1'b0; meas_req = 1'b1; t3 = cyc;
    goto(t3 + 1); meas_req = 1'b0;
    @(negedge clk);
    chk("lit_l0_start", start_count, 1); chk("lit_l0_rx", rx_valid_out, 1);
    chk("lit_l0_amp", tx_amp_out, 16'h0F00);
    goto(t3 + 2); @(negedge clk);
    chk("lit_l0_finish", finish_count, 1); chk("lit_l0_rx2", rx_valid_out, 0);
    w = t3 + 3;
`ifdef READOUT_TX_RESULT_TIMEOUT_EN
    goto(w + 7); @(negedge clk); chk("lit_to_early", result_valid_out, 0);
    goto(w + 8); @(negedge clk);
    chk("lit_to_resv", result_valid_out, 1); chk("lit_to_flag", timeout_out, 1);
    chk("lit_to_res", result_out, 0); chk("lit_to_ready", req_ready, 1);
`else
    goto(w + 8); @(negedge clk);
    chk("lit_wait_resv", result_valid_out, 0); chk("lit_wait_ready", req_ready, 0);
    goto(w + 20); valid_meas_result_in = 1'b1; meas_result_in = 1'b1;
    goto(w + 21); valid_meas_result_in = 1'b0;
    @(negedge clk); chk("lit_late_resv", result_valid_out, 1); chk("lit_late_to", timeout_out, 0);
`endif
    goto(cyc + 1); meas_req = 1'b1; t4 = cyc;
    goto(t4 + 1); meas_req = 1'b0;
    goto(t4 + 3 + 7); valid_meas_result_in = 1'b1; meas_result_in = 1'b1;
    goto(t4 + 3 + 8); valid_meas_result_in = 1'b0;
    @(negedge clk);
    chk("lit_tie_resv", result_valid_out, 1); chk("lit_tie_res", result_out, 1);
    chk("lit_tie_to", timeout_out, 0);

    goto(cyc + 1); wr(2'd0, 16'd6);
    goto(cyc + 1); wr(2'd1, 16'd1);
    goto(cyc + 1); wr(2'd2, 16'h5555);
    goto(cyc + 1); cfg_wr_en = 1'b0; meas_req = 1'b1; t5 = cyc;
    goto(t5 + 1); meas_req = 1'b0;
    goto(t5 + 3); #2 rst = 1'b0;
    #1;
    chk("lit_arst_tx", tx_valid_out, 0); chk("lit_arst_rx", rx_valid_out, 0);
    chk("lit_arst_amp", tx_amp_out, 0); chk("lit_arst_ready", req_ready, 1);
    goto(t5 + 5); rst = 1'b1;
    goto(t5 + 6); meas_req = 1'b1; t6 = cyc;
    goto(t6 + 1); meas_req = 1'b0;
    @(negedge clk);
    chk("lit_def_tx", tx_valid_out, 1); chk("lit_def_amp", tx_amp_out, 0);
    chk("lit_def_start", start_count, 1);
    goto(t6 + 2); @(negedge clk); chk("lit_def_finish", finish_count, 1);
    goto(t6 + 5); valid_meas_result_in = 1'b1; meas_result_in = 1'b0;
    goto(t6 + 6); valid_meas_result_in = 1'b0;
    @(negedge clk); chk("lit_def_resv", result_valid_out, 1);
    goto(cyc + 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
